mc_port_adapter: RTL and testbench

Memory-port adapter that sits directly downstream of a bps engine's memory-request interface and upstream of one Convey MC port (even or odd half). It buffers engine loads and stores in a request FIFO and issues them under MC read/write stall backpressure. Each load is tagged through `rdctl`, and possibly out-of-order MC read responses are returned to the engine in issue order through a reorder buffer. It also sequences write flushes on the engine's behalf.

---
 rtl/mc_pkg.sv | 19 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/mc_port_adapter.sv | 203 ++++++++++++++++++++
 tb/tb_mc_port_adapter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg -- shared constants and flush-FSM states for the Convey MC port adapter. Rev 1.0
`default_nettype none

package mc_pkg;
  localparam logic [1:0] MC_SIZE_8B    = 2'd3;
  localparam int         ADR_W         = 48;
  localparam int         DATA_W        = 64;
  localparam int         RDCTL_W       = 32;
  localparam int         RDCTL_TAG_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } flush_state_e;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with full/empty flags, show-ahead read. Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

`default_nettype wire

// File: rtl/mc_port_adapter.sv
// mc_port_adapter -- engine-to-MC port adapter: request FIFO, tagged loads with in-order
// reorder buffer, and write-flush sequencing. Rev 1.0
`default_nettype none

module mc_port_adapter
  import mc_pkg::*;
#(
  parameter int REQ_DEPTH = 16,
  parameter int TAG_W     = 5
) (
  input  logic               clk_per,
  input  logic               i_reset_n,
  input  logic               eng_req_vld,
  output logic               eng_req_rdy,
  input  logic               eng_req_st,
  input  logic [ADR_W-1:0]   eng_req_vadr,
  input  logic [DATA_W-1:0]  eng_req_wdata,
  output logic               eng_rsp_vld,
  input  logic               eng_rsp_rdy,
  output logic [DATA_W-1:0]  eng_rsp_data,
  input  logic               eng_flush,
  output logic               eng_flush_done,
  output logic               mc_req_ld,
  output logic               mc_req_st,
  output logic [1:0]         mc_req_size,
  output logic [ADR_W-1:0]   mc_req_vadr,
  output logic [DATA_W-1:0]  mc_req_wrd_rdctl,
  input  logic               mc_rd_rq_stall,
  input  logic               mc_wr_rq_stall,
  input  logic               mc_rsp_push,
  input  logic [RDCTL_W-1:0] mc_rsp_rdctl,
  input  logic [DATA_W-1:0]  mc_rsp_data,
  output logic               mc_rsp_stall,
  output logic               mc_req_flush,
  input  logic               mc_rsp_flush_cmplt,
  output logic               err_spurious
);
  localparam int                SLOTS    = 1 << TAG_W;
  localparam int                REQ_W    = 1 + ADR_W + DATA_W;
  localparam logic [TAG_W-1:0]  TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]    OUT_ONE  = (TAG_W + 1)'(1);
  localparam logic [TAG_W:0]    OUT_FULL = {1'b1, {TAG_W{1'b0}}};

  logic [REQ_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              head_st;
  logic [ADR_W-1:0]  head_vadr;
  logic [DATA_W-1:0] head_wdata;
  logic              issue_ld, issue_st, deliver;
  logic [TAG_W-1:0]  rsp_tag;
  logic              unused_rdctl;

  flush_state_e      state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic              mc_req_ld_q, mc_req_ld_d, mc_req_st_q, mc_req_st_d;
  logic [ADR_W-1:0]  mc_req_vadr_q, mc_req_vadr_d;
  logic [DATA_W-1:0] mc_req_wrd_q, mc_req_wrd_d;
  logic [TAG_W-1:0]  alloc_ptr_q, alloc_ptr_d, head_ptr_q, head_ptr_d;
  logic [TAG_W:0]    outstanding_q, outstanding_d;
  logic [SLOTS-1:0]  slot_busy_q, slot_busy_d, slot_vld_q, slot_vld_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rob_q [SLOTS];
  logic [DATA_W-1:0] rob_d [SLOTS];

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (clk_per),
    .rst_n     (i_reset_n),
    .push      (fifo_push),
    .push_data ({eng_req_st, eng_req_vadr, eng_req_wdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_st, head_vadr, head_wdata} = fifo_rdata;
  assign rsp_tag      = mc_rsp_rdctl[RDCTL_TAG_LSB +: TAG_W];
  assign unused_rdctl = ^mc_rsp_rdctl;

  // rdy_en_q keeps ready low through reset and rises one edge after release.
  assign eng_req_rdy = rdy_en_q && !fifo_full && (state_q == ST_IDLE);
  assign fifo_push   = eng_req_vld && eng_req_rdy;

  assign issue_st = !fifo_empty && head_st && !mc_wr_rq_stall;
  assign issue_ld = !fifo_empty && !head_st && !mc_rd_rq_stall &&
                    (outstanding_q != OUT_FULL) && !slot_busy_q[alloc_ptr_q];
  assign fifo_pop = issue_ld || issue_st;
  assign deliver  = slot_vld_q[head_ptr_q] && eng_rsp_rdy;

  assign eng_rsp_vld      = slot_vld_q[head_ptr_q];
  assign eng_rsp_data     = slot_vld_q[head_ptr_q] ? rob_q[head_ptr_q] : '0;
  assign mc_req_ld        = mc_req_ld_q;
  assign mc_req_st        = mc_req_st_q;
  assign mc_req_size      = MC_SIZE_8B;
  assign mc_req_vadr      = mc_req_vadr_q;
  assign mc_req_wrd_rdctl = mc_req_wrd_q;
  assign mc_rsp_stall     = 1'b0;
  assign err_spurious     = err_q;

  always_comb begin
    rdy_en_d      = 1'b1;
    mc_req_ld_d   = issue_ld;
    mc_req_st_d   = issue_st;
    mc_req_vadr_d = mc_req_vadr_q;
    mc_req_wrd_d  = mc_req_wrd_q;
    alloc_ptr_d   = alloc_ptr_q;
    head_ptr_d    = head_ptr_q;
    outstanding_d = outstanding_q;
    slot_busy_d   = slot_busy_q;
    slot_vld_d    = slot_vld_q;
    err_d         = err_q;
    rob_d         = rob_q;

    if (fifo_pop) begin
      mc_req_vadr_d = head_vadr;
      mc_req_wrd_d  = head_st ? head_wdata : {{(DATA_W - TAG_W){1'b0}}, alloc_ptr_q};
    end
    if (issue_ld) begin
      slot_busy_d[alloc_ptr_q] = 1'b1;
      alloc_ptr_d              = alloc_ptr_q + TAG_ONE;
    end

    if (mc_rsp_push) begin
      if (slot_busy_q[rsp_tag]) begin
        rob_d[rsp_tag]      = mc_rsp_data;
        slot_vld_d[rsp_tag] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Delivery is applied last; a valid head slot can never be the issue slot.
    if (deliver) begin
      slot_vld_d[head_ptr_q]  = 1'b0;
      slot_busy_d[head_ptr_q] = 1'b0;
      head_ptr_d              = head_ptr_q + TAG_ONE;
    end

    case ({issue_ld, deliver})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mc_req_flush   = 1'b0;
    eng_flush_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (eng_flush) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !mc_req_ld_q && !mc_req_st_q) state_d = ST_FLUSH;
      ST_FLUSH: begin
        mc_req_flush = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (mc_rsp_flush_cmplt) begin
          eng_flush_done = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_per or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      rdy_en_q      <= 1'b0;
      mc_req_ld_q   <= 1'b0;
      mc_req_st_q   <= 1'b0;
      mc_req_vadr_q <= '0;
      mc_req_wrd_q  <= '0;
      alloc_ptr_q   <= '0;
      head_ptr_q    <= '0;
      outstanding_q <= '0;
      slot_busy_q   <= '0;
      slot_vld_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_en_q      <= rdy_en_d;
      mc_req_ld_q   <= mc_req_ld_d;
      mc_req_st_q   <= mc_req_st_d;
      mc_req_vadr_q <= mc_req_vadr_d;
      mc_req_wrd_q  <= mc_req_wrd_d;
      alloc_ptr_q   <= alloc_ptr_d;
      head_ptr_q    <= head_ptr_d;
      outstanding_q <= outstanding_d;
      slot_busy_q   <= slot_busy_d;
      slot_vld_q    <= slot_vld_d;
      err_q         <= err_d;
    end
  end

  // Load data needs no reset: it is only visible behind slot_vld.
  always_ff @(posedge clk_per) begin
    rob_q <= rob_d;
  end
endmodule

`default_nettype wire

// File: tb/tb_mc_port_adapter.sv
// tb_mc_port_adapter -- scoreboard bench for mc_port_adapter with directed vectors. Rev 1.0
`default_nettype none

module tb_mc_port_adapter;
  logic        clk_per = 1'b0;
  logic        i_reset_n;
  logic        eng_req_vld, eng_req_rdy, eng_req_st;
  logic [47:0] eng_req_vadr;
  logic [63:0] eng_req_wdata;
  logic        eng_rsp_vld, eng_rsp_rdy;
  logic [63:0] eng_rsp_data;
  logic        eng_flush, eng_flush_done;
  logic        mc_req_ld, mc_req_st;
  logic [1:0]  mc_req_size;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic        mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push;
  logic [31:0] mc_rsp_rdctl;
  logic [63:0] mc_rsp_data;
  logic        mc_rsp_stall, mc_req_flush, mc_rsp_flush_cmplt, err_spurious;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [47:0] vadr;
    logic [63:0] wd;
  } mc_item_t;

  mc_item_t    exp_mc[$];
  logic [63:0] exp_rsp[$];
  mc_item_t    mon_item;
  logic [63:0] mon_data;
  int          checks = 0;
  int          errors = 0;
  int          n_mc = 0;
  int          n_flush = 0;
  logic [4:0]  exp_tag = '0;

  mc_port_adapter #(.REQ_DEPTH(16), .TAG_W(5)) dut (
    .clk_per(clk_per), .i_reset_n(i_reset_n),
    .eng_req_vld(eng_req_vld), .eng_req_rdy(eng_req_rdy), .eng_req_st(eng_req_st),
    .eng_req_vadr(eng_req_vadr), .eng_req_wdata(eng_req_wdata),
    .eng_rsp_vld(eng_rsp_vld), .eng_rsp_rdy(eng_rsp_rdy), .eng_rsp_data(eng_rsp_data),
    .eng_flush(eng_flush), .eng_flush_done(eng_flush_done),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_size(mc_req_size),
    .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
    .mc_rsp_stall(mc_rsp_stall), .mc_req_flush(mc_req_flush),
    .mc_rsp_flush_cmplt(mc_rsp_flush_cmplt), .err_spurious(err_spurious)
  );

  always #5 clk_per = ~clk_per;

  // Monitor: every MC request and every accepted engine response is checked in order.
  always @(negedge clk_per) begin
    if (mc_req_flush) n_flush++;
    if (mc_req_ld || mc_req_st) begin
      n_mc++;
      checks++;
      if (exp_mc.size() == 0) begin
        errors++;
        $display("FAIL mc_req_unexpected: got ld=%0d st=%0d adr=%h d=%h, required no request",
                 mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl);
      end else begin
        mon_item = exp_mc.pop_front();
        if ({mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl} !== mon_item || mc_req_size !== 2'd3) begin
          errors++;
          $display("FAIL mc_req: got ld=%0d st=%0d adr=%h d=%h size=%0d, required ld=%0d st=%0d adr=%h d=%h size=3",
                   mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, mc_req_size,
                   mon_item.ld, mon_item.st, mon_item.vadr, mon_item.wd);
        end
      end
    end
    if (eng_rsp_vld && eng_rsp_rdy) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL eng_rsp_unexpected: got %h, required no response", eng_rsp_data);
      end else begin
        mon_data = exp_rsp.pop_front();
        if (eng_rsp_data !== mon_data) begin
          errors++;
          $display("FAIL eng_rsp_data: got %h, required %h", eng_rsp_data, mon_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_per);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic st, input logic [47:0] adr, input logic [63:0] wd);
    int n = 0;
    eng_req_vld   = 1'b1;
    eng_req_st    = st;
    eng_req_vadr  = adr;
    eng_req_wdata = wd;
    while (!eng_req_rdy && n < 100) begin
      tick();
      n++;
    end
    if (!eng_req_rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got rdy=0 for 100 cycles, required rdy=1");
    end else if (st) begin
      exp_mc.push_back({1'b0, 1'b1, adr, wd});
    end else begin
      exp_mc.push_back({1'b1, 1'b0, adr, {59'b0, exp_tag}});
      exp_tag++;
    end
    tick();
    eng_req_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_mc.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("mc_drain", 64'(exp_mc.size()), 64'd0);
  endtask

  task automatic respond(input logic [4:0] tag, input logic [63:0] d);
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = {27'b0, tag};
    mc_rsp_data  = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ctrl", {52'b0, eng_req_rdy, eng_rsp_vld, eng_flush_done, mc_req_ld, mc_req_st,
                     mc_rsp_stall, mc_req_flush, err_spurious, mc_req_size, 2'b00},
        64'h0c);
    chk("rst_vadr", {16'b0, mc_req_vadr}, 64'd0);
    chk("rst_wrd", mc_req_wrd_rdctl, 64'd0);
    chk("rst_rsp_data", eng_rsp_data, 64'd0);
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_mc.delete();
    exp_rsp.delete();
    exp_tag = '0;
    repeat (2) @(posedge clk_per);
    #1;
    i_reset_n = 1'b1;
    #1;
    chk("rdy_after_deassert", eng_req_rdy, 1'b0);
    tick();
    chk("rdy_first_cycle", eng_req_rdy, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] st_seq;
    int         cnt;
    int         n;
    int         base;
    logic       found;

    eng_req_vld = 0; eng_req_st = 0; eng_req_vadr = '0; eng_req_wdata = '0;
    eng_rsp_rdy = 0; eng_flush = 0; mc_rd_rq_stall = 0; mc_wr_rq_stall = 0;
    mc_rsp_push = 0; mc_rsp_rdctl = '0; mc_rsp_data = '0; mc_rsp_flush_cmplt = 0;
    i_reset_n = 1'b1;
    #1;
    apply_reset();
    eng_rsp_rdy = 1'b1;

    // Three back-to-back stores appear as three consecutive MC store pulses.
    push_req(1'b1, 48'h0000_0000_1000, 64'h1111_2222_3333_4444);
    push_req(1'b1, 48'h0000_0000_1008, 64'h5555_6666_7777_8888);
    push_req(1'b1, 48'h0000_0000_1010, 64'h9999_aaaa_bbbb_cccc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_per);
      st_seq[2-i] = mc_req_st;
      tick();
    end
    chk("store_pulse_seq", {61'b0, st_seq}, 64'b110);
    wait_drain();

    // Loads to tags 0,1,2; responses return 2,0,1 and must deliver 0,1,2.
    push_req(1'b0, 48'h0000_0000_2000, '0);
    push_req(1'b0, 48'h0000_0000_2008, '0);
    push_req(1'b0, 48'h0000_0000_2010, '0);
    wait_drain();
    exp_rsp.push_back(64'hd000_0000_0000_0000);
    exp_rsp.push_back(64'hd111_1111_1111_1111);
    exp_rsp.push_back(64'hd222_2222_2222_2222);
    respond(5'd2, 64'hd222_2222_2222_2222);
    tick();
    respond(5'd0, 64'hd000_0000_0000_0000);
    @(negedge clk_per);
    chk("rsp_vld_before_head", eng_rsp_vld, 1'b0);
    tick();
    respond(5'd1, 64'hd111_1111_1111_1111);
    @(negedge clk_per);
    chk("rsp_vld_latency1", eng_rsp_vld, 1'b1);
    tick();
    mc_rsp_push = 1'b0;
    repeat (3) tick();
    chk("rsp_all_delivered", 64'(exp_rsp.size()), 64'd0);

    // 32 outstanding loads saturate the ROB; the 33rd waits for one delivery.
    apply_reset();
    for (int i = 0; i < 33; i++) push_req(1'b0, 48'h0000_0000_3000 + 48'(i * 8), '0);
    repeat (4) tick();
    chk("ld33_held", 64'(exp_mc.size()), 64'd1);
    exp_rsp.push_back(64'h0123_4567_89ab_cdef);
    respond(5'd0, 64'h0123_4567_89ab_cdef);
    @(negedge clk_per);
    chk("ld33_blocked", mc_req_ld, 1'b0);
    tick();
    mc_rsp_push = 1'b0;
    @(negedge clk_per);
    chk("ld33_deliver_vld", eng_rsp_vld, 1'b1);
    tick();
    @(negedge clk_per);
    chk("ld33_not_yet", mc_req_ld, 1'b0);
    tick();
    @(negedge clk_per);
    chk("ld33_issue_tag0", {mc_req_ld, mc_req_wrd_rdctl[62:0]}, {1'b1, 63'd0});
    tick();
    wait_drain();

    // Read stall while filling the FIFO: no issues, ready drops, then a 16-deep burst.
    apply_reset();
    mc_rd_rq_stall = 1'b1;
    base = n_mc;
    for (int i = 0; i < 16; i++) push_req(1'b0, 48'h0000_0000_4000 + 48'(i * 8), '0);
    chk("fifo_full_rdy", eng_req_rdy, 1'b0);
    chk("stall_no_issue", 64'(n_mc - base), 64'd0);
    mc_rd_rq_stall = 1'b0;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_per);
      if (mc_req_ld) cnt++;
      tick();
    end
    chk("burst16", 64'(cnt), 64'd16);
    @(negedge clk_per);
    chk("burst_end", mc_req_ld, 1'b0);
    tick();
    wait_drain();

    // Flush with 4 queued stores; outstanding loads must not delay it.
    mc_wr_rq_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b1, 48'h0000_0000_5000 + 48'(i * 8), 64'hf000 + 64'(i));
    eng_flush = 1'b1;
    tick();
    eng_flush = 1'b0;
    chk("drain_rdy_low", eng_req_rdy, 1'b0);
    mc_wr_rq_stall = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 50 && !found) begin
      @(negedge clk_per);
      if (mc_req_flush) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    chk("flush_seen", found, 1'b1);
    chk("flush_after_stores", 64'(exp_mc.size()), 64'd0);
    chk("flush_rdy_low", eng_req_rdy, 1'b0);
    tick();
    @(negedge clk_per);
    chk("flush_one_cycle", mc_req_flush, 1'b0);
    tick();
    tick();
    eng_flush = 1'b1;
    tick();
    eng_flush = 1'b0;
    tick();
    mc_rsp_flush_cmplt = 1'b1;
    @(negedge clk_per);
    chk("flush_done_pulse", {eng_flush_done, eng_req_rdy}, 2'b10);
    tick();
    mc_rsp_flush_cmplt = 1'b0;
    @(negedge clk_per);
    chk("flush_done_end", {eng_flush_done, eng_req_rdy}, 2'b01);
    base = n_flush;
    repeat (4) tick();
    chk("flush_ignored_in_wait", 64'(n_flush - base), 64'd0);

    // Reset with loads outstanding: outputs clear at once, late responses are spurious.
    for (int i = 0; i < 5; i++) push_req(1'b0, 48'h0000_0000_6000 + 48'(i * 8), '0);
    wait_drain();
    eng_rsp_rdy = 1'b0;
    respond(5'd0, 64'hcafe_f00d_0000_0001);
    tick();
    mc_rsp_push = 1'b0;
    @(negedge clk_per);
    chk("pre_rst_vld", eng_rsp_vld, 1'b1);
    chk("pre_rst_data", eng_rsp_data, 64'hcafe_f00d_0000_0001);
    #2;
    apply_reset();
    eng_rsp_rdy = 1'b1;
    respond(5'd17, 64'hdead_beef_dead_beef);
    tick();
    mc_rsp_push = 1'b0;
    @(negedge clk_per);
    chk("late_rsp_err", err_spurious, 1'b1);
    chk("late_rsp_no_vld", eng_rsp_vld, 1'b0);
    tick();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
